// File: rtl/pp_pipeline_accel_fifo2axis_reader_if.sv
// Handshake bundles for the FIFO-to-AXI4-Stream reader.
//   pp_ap_fifo_if    : ap_fifo style read port (empty_n / read / dout, first-word-fall-through).
//   pp_axis_video_if : AXI4-Stream video channel (tdata/tvalid/tready/tlast/tuser).
// The master modport is the side that produces data, the slave modport the side that consumes it.

interface pp_ap_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  empty_n;
    logic                  read;
    logic [DATA_WIDTH-1:0] dout;

    modport master (output empty_n, output dout, input read);
    modport slave  (input empty_n, input dout, output read);
endinterface

interface pp_axis_video_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/pp_pipeline_accel_fifo2axis_reader.sv
// Drains one ap_fifo stream and replays it as an AXI4-Stream video master.
// A frame is cols x rows beats: TUSER marks the first beat of the frame, TLAST the
// last beat of each line, and done pulses once the final beat has been accepted.
// A 2-entry skid buffer sits between the FIFO and the stream so that a held-high
// TREADY sustains one beat per clock while the outputs stay registered.
// Optional build macro PP_READER_STATS_EN adds stat_beats / stat_stalls counters.

module pp_pipeline_accel_fifo2axis_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DIM_WIDTH-1:0] cols,
    input  logic [DIM_WIDTH-1:0] rows,
    output logic                 busy,
    output logic                 done,
`ifdef PP_READER_STATS_EN
    output logic [31:0]          stat_beats,
    output logic [31:0]          stat_stalls,
`endif
    pp_ap_fifo_if.slave          fifo,
    pp_axis_video_if.master      m_axis
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic                  tuser;
        logic                  tlast;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    state_t               state;
    logic [DIM_WIDTH-1:0] cols_m1;
    logic [DIM_WIDTH-1:0] rows_m1;
    logic [DIM_WIDTH-1:0] col_cnt;
    logic [DIM_WIDTH-1:0] row_cnt;

    beat_t                head_q;
    beat_t                tail_q;
    logic [1:0]           occ;
    logic [1:0]           occ_nxt;
    logic                 push;
    logic                 pop;
    beat_t                in_beat;

    // A read only happens while a frame is running and the buffer has a free slot;
    // the FIFO is first-word-fall-through, so the word is captured on the same edge.
    assign fifo.read = (state == RUN) && fifo.empty_n && (occ != 2'd2);
    assign push      = fifo.read;
    assign pop       = (occ != 2'd0) && m_axis.tready;
    assign occ_nxt   = occ + {1'b0, push} - {1'b0, pop};

    assign in_beat.tuser = (col_cnt == '0) && (row_cnt == '0);
    assign in_beat.tlast = (col_cnt == cols_m1);
    assign in_beat.data  = fifo.dout;

    assign m_axis.tvalid = (occ != 2'd0);
    assign m_axis.tdata  = head_q.data;
    assign m_axis.tlast  = head_q.tlast;
    assign m_axis.tuser  = head_q.tuser;

    // Frame sequencing: latch geometry, walk the column/row counters per read, flush, signal done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            cols_m1 <= '0;
            rows_m1 <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every branch sees the
            // pre-edge values of its neighbours, exactly like the flops it describes.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cols_m1 <= cols - 1'b1;
                        rows_m1 <= rows - 1'b1;
                        col_cnt <= '0;
                        row_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ((cols == '0) || (rows == '0)) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        if (col_cnt == cols_m1) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + 1'b1;
                            if (row_cnt == rows_m1) begin
                                state <= FLUSH;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Look at next occupancy so done lands one clock after the last handshake.
                    if (occ_nxt == 2'd0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry skid buffer in FIFO order; head_q always drives the stream outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the two buffer entries are reset because the head drives tdata/tlast/tuser
            // directly and those outputs must read zero out of reset.
            head_q <= '0;
            tail_q <= '0;
            occ    <= 2'd0;
        end else begin
            occ <= occ_nxt;
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head_q <= in_beat;
                    else             tail_q <= in_beat;
                end
                2'b01: begin
                    head_q <= tail_q;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= in_beat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= in_beat;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PP_READER_STATS_EN
    // Per-frame statistics: accepted beats and RUN cycles lost to an empty FIFO, both saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else if ((state == IDLE) && start) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (pop && (stat_beats != '1)) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if ((state == RUN) && (occ != 2'd2) && !fifo.empty_n && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo2axis_reader.sv
// Bench for pp_pipeline_accel_fifo2axis_reader. A queue stands in for the ap_fifo,
// an expected-beat queue describes each frame (data order, TUSER on beat 0, TLAST
// every cols-th beat), and one negedge process checks the stream against it.

`timescale 1ns/1ps

module tb_pp_pipeline_accel_fifo2axis_reader;

    localparam int DW = 32;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [NW-1:0] cols;
    logic [NW-1:0] rows;
    logic          busy;
    logic          done;
`ifdef PP_READER_STATS_EN
    logic [31:0]   stat_beats;
    logic [31:0]   stat_stalls;
`endif

    pp_ap_fifo_if    #(.DATA_WIDTH(DW)) fifo_bus ();
    pp_axis_video_if #(.DATA_WIDTH(DW)) axis_bus ();

    pp_pipeline_accel_fifo2axis_reader #(.DATA_WIDTH(DW), .DIM_WIDTH(NW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .cols    (cols),
        .rows    (rows),
        .busy    (busy),
        .done    (done),
`ifdef PP_READER_STATS_EN
        .stat_beats  (stat_beats),
        .stat_stalls (stat_stalls),
`endif
        .fifo    (fifo_bus),
        .m_axis  (axis_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            user;
        bit            last;
    } exp_t;

    logic [DW-1:0] fifo_q[$];
    exp_t          exp_q[$];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int done_due   = -1;
    int done_cyc   = 0;
    int occ_m      = 0;
    int reads_left = 0;
    int nbeats     = 0;
    int start_c    = 0;
    int tready_mode = 0;
    int gap_pct    = 0;
    int starve_cnt = 0;
    bit pop_pending = 0;
    bit done_seen  = 0;
    bit prev_hold  = 0;
    logic [DW-1:0] prev_data;
    logic          prev_user;
    logic          prev_last;
    logic [DW-1:0] obs_data[16];
    bit   [15:0]   obs_user;
    bit   [15:0]   obs_last;
    int            hs_cyc[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model and stream-ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        bit gap;
        #1;
        if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
        pop_pending = 0;
        case (tready_mode)
            0:       axis_bus.tready = 1'b1;
            1:       axis_bus.tready = ~axis_bus.tready;
            2:       axis_bus.tready = 1'($urandom_range(0, 1));
            default: axis_bus.tready = 1'b0;
        endcase
        gap = (gap_pct > 0) && ($urandom_range(0, 99) < gap_pct);
        if (starve_cnt > 0) begin
            gap = 1;
            starve_cnt--;
        end
        fifo_bus.empty_n = (fifo_q.size() > 0) && !gap;
        fifo_bus.dout    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    // Compare process: everything the DUT shows is checked against the frame model each cycle.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_hold   = 0;
            pop_pending = 0;
        end else begin
            check("done", done, cyc == done_due);
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                check("busy_at_done", busy, 0);
            end
            check("tvalid_vs_occ", axis_bus.tvalid, occ_m != 0);
            if (prev_hold) begin
                check("hold_tvalid", axis_bus.tvalid, 1);
                check("hold_tdata", axis_bus.tdata, prev_data);
                check("hold_tuser", axis_bus.tuser, prev_user);
                check("hold_tlast", axis_bus.tlast, prev_last);
            end
            if (fifo_bus.read) begin
                check("read_nonempty", fifo_bus.empty_n, 1);
                check("read_occ_lt2", occ_m < 2, 1);
                check("read_in_frame", reads_left > 0, 1);
                reads_left--;
            end
            if (axis_bus.tvalid && axis_bus.tready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("tdata", axis_bus.tdata, e.data);
                    check("tuser", axis_bus.tuser, e.user);
                    check("tlast", axis_bus.tlast, e.last);
                    if (exp_q.size() == 0) done_due = cyc + 1;
                end
                if (nbeats < 16) begin
                    obs_data[nbeats] = axis_bus.tdata;
                    obs_user[nbeats] = axis_bus.tuser;
                    obs_last[nbeats] = axis_bus.tlast;
                    hs_cyc[nbeats]   = cyc;
                end
                nbeats++;
                occ_m--;
            end
            if (fifo_bus.read) occ_m++;
            pop_pending = fifo_bus.read;
            prev_hold   = axis_bus.tvalid && !axis_bus.tready;
            prev_data   = axis_bus.tdata;
            prev_user   = axis_bus.tuser;
            prev_last   = axis_bus.tlast;
        end
    end

    task automatic load_frame(input int c, input int r, input bit rnd, input logic [DW-1:0] base);
        for (int i = 0; i < c * r; i++) begin
            logic [DW-1:0] w;
            w = rnd ? DW'($urandom) : base + DW'(i);
            fifo_q.push_back(w);
            exp_q.push_back('{data: w, user: (i == 0), last: ((i % c) == c - 1)});
        end
        reads_left += c * r;
    endtask

    task automatic start_frame(input int c, input int r);
        @(posedge clk);
        #2;
        start     = 1'b1;
        cols      = NW'(c);
        rows      = NW'(r);
        start_c   = cyc;
        nbeats    = 0;
        obs_user  = '0;
        obs_last  = '0;
        done_seen = 0;
        if (c == 0 || r == 0) done_due = cyc + 3;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget && !done_seen; i++) @(negedge clk);
        check(name, done_seen, 1);
        @(negedge clk);
        check({name, "_busy_low"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        start            = 1'b0;
        cols             = '0;
        rows             = '0;
        fifo_bus.empty_n = 1'b0;
        fifo_bus.dout    = '0;
        axis_bus.tready  = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_read", fifo_bus.read, 0);
        check("rst_tvalid", axis_bus.tvalid, 0);
        check("rst_tlast", axis_bus.tlast, 0);
        check("rst_tuser", axis_bus.tuser, 0);
        check("rst_tdata", axis_bus.tdata, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // 1: 4x2 frame, FIFO pre-filled, tready held high.
        tready_mode = 0;
        load_frame(4, 2, 0, 32'hA000_0000);
        repeat (3) @(posedge clk);
        start_frame(4, 2);
        check("t1_busy_high", busy, 1);
        wait_done(100, "t1_done");
        check("t1_count", nbeats, 8);
        check("t1_user", obs_user[7:0], 8'b0000_0001);
        check("t1_last", obs_last[7:0], 8'b1000_1000);
        check("t1_data5", obs_data[5], 32'hA000_0005);
        check("t1_first_latency", hs_cyc[0] - start_c, 3);
        check("t1_back_to_back", hs_cyc[7] - hs_cyc[0], 7);
        check("t1_done_latency", done_cyc - hs_cyc[7], 1);

        // 2: tready toggling, plus a start pulse with cols=9 while busy.
        tready_mode = 1;
        load_frame(4, 2, 0, 32'hB000_0000);
        start_frame(4, 2);
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1;
        cols  = NW'(9);
        rows  = NW'(9);
        @(posedge clk);
        #2 start = 1'b0;
        check("t2_busy_during", busy, 1);
        wait_done(200, "t2_done");
        check("t2_count", nbeats, 8);
        check("t2_user", obs_user[7:0], 8'b0000_0001);
        check("t2_last", obs_last[7:0], 8'b1000_1000);
        check("t2_data7", obs_data[7], 32'hB000_0007);

        // 3: FIFO starved for 5 cycles mid-line.
        tready_mode = 0;
        load_frame(4, 2, 0, 32'hC000_0000);
        start_frame(4, 2);
        for (int i = 0; i < 50 && nbeats < 2; i++) @(negedge clk);
        starve_cnt = 5;
        wait_done(200, "t3_done");
        check("t3_count", nbeats, 8);
        check("t3_last", obs_last[7:0], 8'b1000_1000);
`ifdef PP_READER_STATS_EN
        check("t3_stat_stalls", stat_stalls, 5);
        check("t3_stat_beats", stat_beats, 8);
`endif

        // 4: empty geometry (cols=0, then rows=0) -> no reads, done two clocks after start.
        start_frame(0, 3);
        wait_done(20, "t4_done");
        check("t4_done_latency", done_cyc - start_c, 3);
        check("t4_no_beats", nbeats, 0);
        start_frame(5, 0);
        wait_done(20, "t4b_done");
        check("t4b_done_latency", done_cyc - start_c, 3);

        // 5: reset mid-frame with the buffer full, then a clean 2x1 frame.
        tready_mode = 3;
        load_frame(4, 2, 0, 32'hD000_0000);
        start_frame(4, 2);
        repeat (6) @(posedge clk);
        #3;
        check("t5_tvalid_before", axis_bus.tvalid, 1);
        check("t5_read_blocked", fifo_bus.read, 0);
        check("t5_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t5_rst_tvalid", axis_bus.tvalid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_read", fifo_bus.read, 0);
        fifo_q.delete();
        exp_q.delete();
        occ_m       = 0;
        reads_left  = 0;
        done_due    = -1;
        pop_pending = 0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        tready_mode = 0;
        load_frame(2, 1, 0, 32'hE000_0000);
        start_frame(2, 1);
        wait_done(50, "t5_done");
        check("t5_count", nbeats, 2);
        check("t5_user", obs_user[1:0], 2'b01);
        check("t5_last", obs_last[1:0], 2'b10);

        // 6: random geometry, random tready, random FIFO gaps.
        tready_mode = 2;
        gap_pct     = 30;
        for (int f = 0; f < 8; f++) begin
            int c;
            int r;
            c = (f == 0) ? 1 : int'($urandom_range(1, 5));
            r = (f == 0) ? 3 : int'($urandom_range(1, 3));
            load_frame(c, r, 1, '0);
            start_frame(c, r);
            wait_done(600, "t6_done");
            check("t6_count", nbeats, c * r);
        end
        gap_pct = 0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
